// File: rtl/otter_pkg.sv
// Shared constants and types for the OTTER core.
// Register-file widths live here so every stage agrees on them.
package otter_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/otter_reg_file.sv
// OTTER RV32I integer register file: 2 async read ports, 1 sync write port.
// x0 is not stored and is forced to zero on both read paths.
module otter_reg_file
    import otter_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  reg_addr_t r_addr1,
    input  reg_addr_t r_addr2,
    input  logic      w_en,
    input  reg_addr_t w_addr,
    input  word_t     w_data,
    output word_t     r_rs1,
    output word_t     r_rs2
);

    word_t regs_q [1:NREGS-1];
    word_t regs_d [1:NREGS-1];

    // Next-state: only the addressed non-zero register takes w_data.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREGS; i++) begin
            if (w_en && (w_addr == reg_addr_t'(i))) begin
                regs_d[i] = w_data;
            end
        end
    end

    // Storage with asynchronous clear; reset dominates any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: address 0 and unmatched addresses yield zero.
    always_comb begin
        r_rs1 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (r_addr1 == reg_addr_t'(i)) begin
                r_rs1 = regs_q[i];
            end
        end
    end

    // Read port 2: independent copy of the port 1 read path.
    always_comb begin
        r_rs2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (r_addr2 == reg_addr_t'(i)) begin
                r_rs2 = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_otter_reg_file.sv
// Directed self-checking bench for otter_reg_file.
// Expected values are hand-computed constants in each step.
module tb_otter_reg_file;
    import otter_pkg::*;

    logic      clk;
    logic      rst_n;
    reg_addr_t r_addr1;
    reg_addr_t r_addr2;
    logic      w_en;
    reg_addr_t w_addr;
    word_t     w_data;
    word_t     r_rs1;
    word_t     r_rs2;

    int checks;
    int errors;

    otter_reg_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .r_addr1 (r_addr1),
        .r_addr2 (r_addr2),
        .w_en    (w_en),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .r_rs1   (r_rs1),
        .r_rs2   (r_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input reg_addr_t a, input word_t d);
        @(negedge clk);
        w_en   = 1'b1;
        w_addr = a;
        w_data = d;
        @(posedge clk);
        #1;
        w_en = 1'b0;
    endtask

    task automatic rd1(input reg_addr_t a, input string tag, input word_t exp);
        r_addr1 = a;
        #1;
        chk(tag, r_rs1, exp);
    endtask

    word_t pat [8];

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        r_addr1 = '0;
        r_addr2 = '0;
        w_en    = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        pat[0] = 32'h0000_0000;
        pat[1] = 32'hFFFF_FFFF;
        pat[2] = 32'hAAAA_AAAA;
        pat[3] = 32'h5555_5555;
        pat[4] = 32'h1234_5678;
        pat[5] = 32'h8765_4321;
        pat[6] = 32'hF0F0_F0F0;
        pat[7] = 32'h0F0F_0F0F;

        #2;
        r_addr1 = 5'd7;
        r_addr2 = 5'd31;
        #1;
        chk("reset_rs1", r_rs1, 32'h0);
        chk("reset_rs2", r_rs2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rd1(reg_addr_t'(i), $sformatf("init_x%0d", i), 32'h0);
        end

        wr(5'd1, 32'hDEAD_BEEF);
        rd1(5'd1, "basic_x1", 32'hDEAD_BEEF);
        wr(5'd0, 32'hDEAD_BEEF);
        rd1(5'd0, "x0_rs1", 32'h0);
        r_addr2 = 5'd0;
        #1;
        chk("x0_rs2", r_rs2, 32'h0);

        wr(5'd5, 32'h1234_5678);
        wr(5'd10, 32'h8765_4321);
        r_addr1 = 5'd5;
        r_addr2 = 5'd10;
        #1;
        chk("dual_rs1", r_rs1, 32'h1234_5678);
        chk("dual_rs2", r_rs2, 32'h8765_4321);
        r_addr2 = 5'd5;
        #1;
        chk("same_addr_rs2", r_rs2, 32'h1234_5678);

        wr(5'd3, 32'hABCD_EF00);
        @(negedge clk);
        w_en   = 1'b0;
        w_addr = 5'd3;
        w_data = 32'h1111_1111;
        @(posedge clk);
        #1;
        rd1(5'd3, "wen0_x3", 32'hABCD_EF00);

        for (int i = 0; i < 8; i++) begin
            wr(reg_addr_t'(20 + i), pat[i]);
        end
        wr(5'd31, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            rd1(reg_addr_t'(20 + i), $sformatf("pat_x%0d", 20 + i), pat[i]);
        end
        rd1(5'd31, "x31", 32'hFFFF_FFFF);

        wr(5'd15, 32'hCAFE_BABE);
        @(negedge clk);
        r_addr1 = 5'd15;
        r_addr2 = 5'd16;
        w_en    = 1'b1;
        w_addr  = 5'd16;
        w_data  = 32'hDEAD_C0DE;
        #1;
        chk("rdw_other_pre", r_rs1, 32'hCAFE_BABE);
        chk("rdw_same_pre", r_rs2, 32'h0);
        @(posedge clk);
        #1;
        w_en = 1'b0;
        chk("rdw_other_post", r_rs1, 32'hCAFE_BABE);
        chk("rdw_same_post", r_rs2, 32'hDEAD_C0DE);

        @(negedge clk);
        w_en   = 1'b1;
        w_addr = 5'd7;
        w_data = 32'h0000_0001;
        @(negedge clk);
        w_data = 32'h0000_0002;
        @(negedge clk);
        w_en = 1'b0;
        rd1(5'd7, "b2b_same", 32'h0000_0002);

        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            w_en   = 1'b1;
            w_addr = reg_addr_t'(i);
            w_data = 32'h1000_0000 + i;
        end
        @(negedge clk);
        w_en = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rd1(reg_addr_t'(i), $sformatf("sweep_x%0d", i), 32'h1000_0000 + i);
        end
        rd1(5'd0, "sweep_x0", 32'h0);

        @(negedge clk);
        w_en   = 1'b1;
        w_addr = 5'd9;
        w_data = 32'h5A5A_5A5A;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r_addr1 = reg_addr_t'(i);
            r_addr2 = reg_addr_t'(31 - i);
            #1;
            chk($sformatf("rst_rs1_x%0d", i), r_rs1, 32'h0);
            chk($sformatf("rst_rs2_x%0d", 31 - i), r_rs2, 32'h0);
        end
        @(posedge clk);
        #1;
        rd1(5'd9, "rst_mid_write", 32'h0);
        @(negedge clk);
        w_en  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd1(5'd9, "post_rst_x9", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
